// File: rtl/traffic_input_cond.sv
// Input conditioning for the traffic controller:
// sync + debounce of raw inputs, sticky walk request, tick timebase.

module traffic_db_stage #(
  parameter int DB_CYCLES = 1000000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic stable
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DB_CYCLES - 1);

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          stb_q, stb_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Two-flop sync, then count consecutive differing samples.
  always_comb begin
    s1_d  = raw;
    s2_d  = s1_q;
    stb_d = stb_q;
    cnt_d = '0;
    if (s2_q != stb_q) begin
      if (cnt_q == CMAX) begin
        stb_d = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Sync and debounce state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      stb_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      stb_q <= stb_d;
      cnt_q <= cnt_d;
    end
  end

  assign stable = stb_q;

endmodule

module traffic_input_cond #(
  parameter int TICK_DIV  = 100000000,
  parameter int DB_CYCLES = 1000000
) (
  input  logic clock,
  input  logic reset,
  input  logic walk_btn,
  input  logic sensor_in,
  input  logic walk_ack,
  output logic tick,
  output logic sensor,
  output logic walk_req
);

  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TMAX = TW'(TICK_DIV - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_e;

  logic          walk_stb;
  logic          walk_prev_q, walk_prev_d;
  logic          walk_rise;
  state_e        state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          tick_q, tick_d;

  traffic_db_stage #(
    .DB_CYCLES(DB_CYCLES)
  ) u_db_walk (
    .clock (clock),
    .reset (reset),
    .raw   (walk_btn),
    .stable(walk_stb)
  );

  traffic_db_stage #(
    .DB_CYCLES(DB_CYCLES)
  ) u_db_sensor (
    .clock (clock),
    .reset (reset),
    .raw   (sensor_in),
    .stable(sensor)
  );

  assign walk_rise = walk_stb & ~walk_prev_q;

  // Walk request FSM; a fresh rise beats a same-cycle ack.
  always_comb begin
    walk_prev_d = walk_stb;
    state_d     = state_q;
    unique case (state_q)
      IDLE: begin
        if (walk_rise) state_d = PENDING;
      end
      PENDING: begin
        if (!walk_rise && walk_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Free-running timebase, pulse on wrap.
  always_comb begin
    tick_d = (tcnt_q == TMAX);
    tcnt_d = tick_d ? '0 : tcnt_q + 1'b1;
  end

  // Request and timebase registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      walk_prev_q <= 1'b0;
      state_q     <= IDLE;
      tcnt_q      <= '0;
      tick_q      <= 1'b0;
    end else begin
      walk_prev_q <= walk_prev_d;
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      tick_q      <= tick_d;
    end
  end

  assign walk_req = (state_q == PENDING);
  assign tick     = tick_q;

endmodule

// File: tb/tb_traffic_input_cond.sv
// Directed bench for traffic_input_cond
// with TICK_DIV=10, DB_CYCLES=4.

module tb_traffic_input_cond;

  logic clock     = 1'b0;
  logic reset     = 1'b1;
  logic walk_btn  = 1'b0;
  logic sensor_in = 1'b0;
  logic walk_ack  = 1'b0;
  logic tick;
  logic sensor;
  logic walk_req;

  int errs   = 0;
  int checks = 0;

  traffic_input_cond #(
    .TICK_DIV (10),
    .DB_CYCLES(4)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .walk_btn (walk_btn),
    .sensor_in(sensor_in),
    .walk_ack (walk_ack),
    .tick     (tick),
    .sensor   (sensor),
    .walk_req (walk_req)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #2 reset = 1'b0;
    #1;
    chk("rst_tick", tick, 1'b0);
    chk("rst_sensor", sensor, 1'b0);
    chk("rst_walk", walk_req, 1'b0);
    repeat (3) step();
    @(negedge clock);
    reset = 1'b1;

    for (int n = 1; n <= 30; n++) begin
      step();
      chk("tick_run", tick, (n % 10) == 0);
      chk("idle_sensor", sensor, 1'b0);
      chk("idle_walk", walk_req, 1'b0);
    end

    sensor_in = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      step();
      chk("sensor_rise", sensor, n >= 6);
    end
    sensor_in = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      step();
      chk("sensor_fall", sensor, n < 6);
    end
    sensor_in = 1'b1;
    repeat (3) step();
    sensor_in = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      step();
      chk("sensor_glitch", sensor, 1'b0);
    end

    walk_btn = 1'b1;
    for (int n = 1; n <= 3; n++) begin
      step();
      chk("walk_burst", walk_req, 1'b0);
    end
    walk_btn = 1'b0;
    step();
    chk("walk_gap", walk_req, 1'b0);
    walk_btn = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      step();
      chk("walk_press", walk_req, n >= 7);
    end

    walk_ack = 1'b1;
    step();
    walk_ack = 1'b0;
    chk("ack_clear", walk_req, 1'b0);
    for (int n = 1; n <= 10; n++) begin
      step();
      chk("held_no_reassert", walk_req, 1'b0);
    end

    walk_ack = 1'b1;
    for (int n = 1; n <= 3; n++) begin
      step();
      chk("ack_idle", walk_req, 1'b0);
    end
    walk_ack = 1'b0;

    walk_btn = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      step();
      chk("release", walk_req, 1'b0);
    end
    walk_btn = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      step();
      chk("repress", walk_req, n >= 7);
    end

    walk_btn = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      step();
      chk("fall_no_effect", walk_req, 1'b1);
    end

    walk_btn = 1'b1;
    repeat (6) step();
    chk("pre_collide", walk_req, 1'b1);
    walk_ack = 1'b1;
    step();
    walk_ack = 1'b0;
    chk("set_wins", walk_req, 1'b1);
    step();
    chk("set_wins_hold", walk_req, 1'b1);

    sensor_in = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    #1;
    chk("mid_rst_tick", tick, 1'b0);
    chk("mid_rst_sensor", sensor, 1'b0);
    chk("mid_rst_walk", walk_req, 1'b0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      step();
      chk("post_tick", tick, n == 10);
      chk("post_sensor", sensor, n >= 6);
      chk("post_walk", walk_req, n >= 7);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
